// File: rtl/mole_timer_bank.sv
// Bank of independent load-and-expire countdown timers sharing one prescaler.
// Each channel is one-shot or auto-reload and reports expiry as a one-cycle pulse.
module mole_timer_bank #(
  parameter int NUM_CH   = 8,
  parameter int WIDTH    = 28,
  parameter int PRESCALE = 1,
  parameter int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] loadval,
  input  logic [NUM_CH-1:0]       auto_reload,
  input  logic [NUM_CH-1:0]       cancel,
  input  logic                    pause,
  input  logic [IDX_W-1:0]        sel_ch,
  output logic [WIDTH-1:0]        count_out,
  output logic [NUM_CH-1:0]       active,
  output logic [NUM_CH-1:0]       expire_pulse,
  output logic                    any_expire,
  output logic [IDX_W-1:0]        expire_ch
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  logic [PS_W-1:0]   presc;
  logic              tick;

  ch_state_t         state     [NUM_CH];
  ch_state_t         state_nxt [NUM_CH];
  logic [WIDTH-1:0]  cnt       [NUM_CH];
  logic [WIDTH-1:0]  cnt_nxt   [NUM_CH];
  logic [WIDTH-1:0]  rel       [NUM_CH];
  logic [WIDTH-1:0]  rel_nxt   [NUM_CH];
  logic [NUM_CH-1:0] mode;
  logic [NUM_CH-1:0] mode_nxt;
  logic [NUM_CH-1:0] pulse_nxt;
  logic [IDX_W-1:0]  ch_nxt;

  // Prescaler is never realigned by load, so first-tick latency depends on its phase.
  assign tick = !pause && (presc == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (!pause) begin
      presc <= (presc == PS_LAST) ? '0 : presc + PS_W'(1);
    end
  end

  // Per-channel priority: cancel, then load, then (pause-gated) tick.
  always_comb begin
    mode_nxt  = mode;
    pulse_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      rel_nxt[i]   = rel[i];
      if (cancel[i]) begin
        state_nxt[i] = IDLE;
        cnt_nxt[i]   = '0;
      end else if (load[i]) begin
        cnt_nxt[i]   = loadval[i*WIDTH +: WIDTH];
        rel_nxt[i]   = loadval[i*WIDTH +: WIDTH];
        mode_nxt[i]  = auto_reload[i];
        state_nxt[i] = RUN;
      end else if (state[i] == RUN && tick) begin
        if (cnt[i] != '0) begin
          cnt_nxt[i] = cnt[i] - WIDTH'(1);
        end else begin
          pulse_nxt[i] = 1'b1;
          if (mode[i]) begin
            cnt_nxt[i] = rel[i];
          end else begin
            state_nxt[i] = IDLE;
          end
        end
      end
    end
  end

  always_comb begin
    ch_nxt = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pulse_nxt[i]) begin
        ch_nxt = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
        rel[i]   <= '0;
      end
      mode         <= '0;
      expire_pulse <= '0;
      any_expire   <= 1'b0;
      expire_ch    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
        rel[i]   <= rel_nxt[i];
      end
      mode         <= mode_nxt;
      expire_pulse <= pulse_nxt;
      any_expire   <= |pulse_nxt;
      expire_ch    <= ch_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      active[i] = (state[i] == RUN);
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    count_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_ch == IDX_W'(i)) begin
        count_out = cnt[i];
      end
    end
  end

endmodule

// File: doc/mole_timer_bank.md
Name: mole_timer_bank

Overview:
- Multi-channel, parametrised successor of the board's single count-down timer; one independent channel per mole hole plus game-level timers.
- Each channel is load-and-expire: one-shot or auto-reload, with a shared prescaler and a global pause.
- Expiry is a single-cycle pulse, not a sticky level.
- Sits between the board state machine (load/cancel/pause) and the mole controllers (expire pulses, remaining-time readback).

Parameters:
- NUM_CH, 8: number of independent timer channels (1..32).
- WIDTH, 28: counter width per channel in bits.
- PRESCALE, 1: clk cycles per timer tick (>=1). 1 means one decrement per clk.
- IDX_W, $clog2(NUM_CH) (min 1): width of channel index ports.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  NUM_CH  per-channel load strobe, active high.
- loadval  in  NUM_CH*WIDTH  packed load values; channel i uses bits [i*WIDTH +: WIDTH].
- auto_reload  in  NUM_CH  per-channel mode, sampled with load: 1 = periodic, 0 = one-shot.
- cancel  in  NUM_CH  per-channel abort strobe, active high.
- pause  in  1  global freeze of prescaler and all counters.
- sel_ch  in  IDX_W  channel select for count_out.
- count_out  out  WIDTH  combinational: current counter of channel sel_ch; 0 if sel_ch >= NUM_CH.
- active  out  NUM_CH  registered: channel is in RUN state.
- expire_pulse  out  NUM_CH  registered: one-cycle expiry pulse per channel.
- any_expire  out  1  registered: OR of the expire_pulse bits, same cycle.
- expire_ch  out  IDX_W  registered: lowest index with expire_pulse set; 0 when any_expire = 0.

Behaviour:
- Reset (asynchronous): all counters = 0, reload registers = 0, mode bits = 0, prescaler = 0; all channels IDLE; every output register = 0.
- Prescaler:
  - Free-running counter 0..PRESCALE-1; tick = (prescaler == PRESCALE-1).
  - PRESCALE = 1 gives tick every cycle.
  - Holds while pause = 1.
  - Not realigned by load, so first-tick latency after load varies by 0..PRESCALE-1 cycles.
- Per-channel state machine, IDLE/RUN, priority per cycle: cancel > load > pause > tick.
  - cancel: state IDLE, counter = 0, no pulse, even if expiry would occur this cycle.
  - load (any state): counter = loadval, reload register = loadval, mode = auto_reload, state RUN, no pulse this cycle. Overrides a coincident expiry.
  - RUN, tick, counter > 0: counter decrements by 1.
  - RUN, tick, counter == 0:
    - expire_pulse[i] = 1 for exactly one cycle.
    - Auto-reload: counter = reload register, stay in RUN.
    - One-shot: go to IDLE, counter stays 0.
  - IDLE: counter holds; no pulses.
- Timing with PRESCALE = 1, load sampled at edge E0 with value N: expire_pulse is high in the cycle after edge E0+N+1, i.e. N+1 cycles after load. Auto-reload period is N+1 ticks. N = 0 gives a pulse every tick.
- Pause: counters and prescaler freeze; load and cancel still take effect immediately; no expiry while paused.
- Simultaneous events on different channels are independent. expire_ch resolves ties to the lowest index; expire_pulse shows all of them.
- Arithmetic: unsigned; no wrap below 0, because the zero case is handled by the expiry path. loadval uses the full WIDTH range.
- Reset mid-count: channel goes to IDLE immediately; any pulse in flight is dropped.

Test Plan:
- Reset, then load[2] = 1 with loadval = 5, one-shot, PRESCALE = 1 -> expire_pulse[2] high exactly 6 cycles after the load edge, for 1 cycle; active[2] falls on the same edge; count_out with sel_ch = 2 reads 5,4,3,2,1,0.
- Channel 0 auto-reload with loadval = 3 -> pulses every 4 cycles for at least 5 periods; active[0] stays 1.
- Load ch1 = 4 and ch6 = 4 on the same cycle -> both pulses in the same cycle; any_expire = 1; expire_ch = 1.
- Ch3 loaded with 10, pause asserted for 7 cycles mid-count -> expiry delayed by exactly 7 cycles; a load to ch4 during the pause still sets active[4] = 1.
- Cancel and load asserted on ch5 in its expiry cycle -> no pulse, IDLE, counter 0. Load alone in the expiry cycle -> no pulse, restarts from the new value.
- PRESCALE = 4, loadval = 2 -> expiry 9..12 cycles after load depending on prescaler phase; rst_n pulled low mid-count -> all outputs 0 asynchronously, no later pulse.
